// File: rtl/reversi_pkg.sv
// Shared reversi definitions: cell encoding, start position, sequencer state
// encoding and the cell index helper.
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Cells 27,36 white; cells 28,35 black (cell i occupies bits [2i+1:2i]).
  localparam logic [127:0] START_BOARD = (128'd1 << 55) | (128'd1 << 73) |
                                         (128'd1 << 56) | (128'd1 << 70);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StFlip,
    StCommit,
    StCount,
    StReject,
    StPass
  } seq_state_e;

  function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/disc_counter.sv
// Combinational popcount of black and white discs over the 64-cell board.
module disc_counter
  import reversi_pkg::*;
(
  input  logic [127:0] board_i,
  output logic [6:0]   black_cnt_o,
  output logic [6:0]   white_cnt_o
);

  always_comb begin
    black_cnt_o = '0;
    white_cnt_o = '0;
    for (int i = 0; i < 64; i++) begin
      if (board_i[2*i +: 2] == CELL_BLACK) black_cnt_o = black_cnt_o + 7'd1;
      if (board_i[2*i +: 2] == CELL_WHITE) white_cnt_o = white_cnt_o + 7'd1;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Game-level reversi controller: owns the board and turn, sequences checker and
// flip datapath per move, commits results, tracks passes, counts and game over.
module move_sequencer
  import reversi_pkg::*;
#(
  parameter int unsigned FLIP_LAT = 1,
  parameter int unsigned CHK_TMO  = 255
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         new_game,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [2:0]   move_x,
  input  logic [2:0]   move_y,
  input  logic         pass_req,
  output logic         chk_start,
  output logic [2:0]   chk_x,
  output logic [2:0]   chk_y,
  input  logic         chk_done,
  input  logic [7:0]   chk_dirs,
  input  logic [47:0]  chk_ends,
  output logic         flp_start,
  output logic [7:0]   flp_dirs,
  output logic [47:0]  flp_ends,
  input  logic [127:0] flp_new_board,
  output logic [127:0] board,
  output logic         player_black,
  output logic         move_accepted,
  output logic         move_rejected,
  output logic [6:0]   black_cnt,
  output logic [6:0]   white_cnt,
  output logic         game_over
);

  localparam int unsigned TmrW     = (CHK_TMO > 1) ? $clog2(CHK_TMO) : 1;
  localparam int unsigned TmoLast  = (CHK_TMO > 0) ? CHK_TMO - 1 : 0;
  localparam int unsigned FlpW     = (FLIP_LAT > 1) ? $clog2(FLIP_LAT) : 1;
  localparam int unsigned FlipLast = (FLIP_LAT > 0) ? FLIP_LAT - 1 : 0;

  seq_state_e     state_q, state_d;
  logic [127:0]   board_q, board_d;
  logic           player_black_q, player_black_d;
  logic           game_over_q, game_over_d;
  logic [1:0]     pass_cnt_q, pass_cnt_d;
  logic [2:0]     x_q, x_d, y_q, y_d;
  logic [7:0]     dirs_q, dirs_d;
  logic [47:0]    ends_q, ends_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [FlpW-1:0] flp_cnt_q, flp_cnt_d;
  logic           chk_start_q, chk_start_d;
  logic           flp_start_q, flp_start_d;
  logic           accepted_q, accepted_d;
  logic           rejected_q, rejected_d;
  logic [6:0]     black_cnt_q, black_cnt_d, white_cnt_q, white_cnt_d;

  logic [6:0]     pop_black, pop_white;
  logic [1:0]     mover_cell;
  logic [6:0]     req_bit, placed_bit;

  disc_counter u_disc_counter (
    .board_i     (board_q),
    .black_cnt_o (pop_black),
    .white_cnt_o (pop_white)
  );

  assign move_ready = (state_q == StIdle) && !game_over_q;
  assign mover_cell = player_black_q ? CELL_BLACK : CELL_WHITE;
  assign req_bit    = {cell_idx(move_x, move_y), 1'b0};
  assign placed_bit = {cell_idx(x_q, y_q), 1'b0};

  always_comb begin
    state_d        = state_q;
    board_d        = board_q;
    player_black_d = player_black_q;
    game_over_d    = game_over_q;
    pass_cnt_d     = pass_cnt_q;
    x_d            = x_q;
    y_d            = y_q;
    dirs_d         = dirs_q;
    ends_d         = ends_q;
    tmr_d          = tmr_q;
    flp_cnt_d      = flp_cnt_q;
    black_cnt_d    = black_cnt_q;
    white_cnt_d    = white_cnt_q;
    chk_start_d    = 1'b0;
    flp_start_d    = 1'b0;
    accepted_d     = 1'b0;
    rejected_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A move request takes priority over a simultaneous pass request.
        if (move_valid && move_ready) begin
          x_d = move_x;
          y_d = move_y;
          if (board_q[req_bit +: 2] != CELL_EMPTY) begin
            rejected_d = 1'b1;
            state_d    = StReject;
          end else begin
            chk_start_d = 1'b1;
            tmr_d       = '0;
            state_d     = StCheck;
          end
        end else if (pass_req && !game_over_q) begin
          state_d = StPass;
        end
      end
      StCheck: begin
        if (chk_done) begin
          if (chk_dirs == '0) begin
            rejected_d = 1'b1;
            state_d    = StReject;
          end else begin
            dirs_d      = chk_dirs;
            ends_d      = chk_ends;
            flp_start_d = 1'b1;
            flp_cnt_d   = '0;
            state_d     = (FLIP_LAT == 0) ? StCommit : StFlip;
          end
        end else if (tmr_q == TmrW'(TmoLast)) begin
          rejected_d = 1'b1;
          state_d    = StReject;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StFlip: begin
        if (flp_cnt_q == FlpW'(FlipLast)) state_d = StCommit;
        else flp_cnt_d = flp_cnt_q + 1'b1;
      end
      StCommit: begin
        // The datapath result excludes the placed disc, so force it here.
        board_d                 = flp_new_board;
        board_d[placed_bit +: 2] = mover_cell;
        player_black_d          = !player_black_q;
        pass_cnt_d              = '0;
        accepted_d              = 1'b1;
        state_d                 = StCount;
      end
      StCount: begin
        black_cnt_d = pop_black;
        white_cnt_d = pop_white;
        if (({1'b0, pop_black} + {1'b0, pop_white}) == 8'd64 ||
            pop_black == '0 || pop_white == '0) begin
          game_over_d = 1'b1;
        end
        state_d = StIdle;
      end
      StReject: state_d = StIdle;
      StPass: begin
        player_black_d = !player_black_q;
        pass_cnt_d     = pass_cnt_q + 2'd1;
        if (pass_cnt_q == 2'd1) game_over_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn || new_game) begin
      state_q        <= StIdle;
      board_q        <= START_BOARD;
      player_black_q <= 1'b1;
      game_over_q    <= 1'b0;
      pass_cnt_q     <= '0;
      x_q            <= '0;
      y_q            <= '0;
      dirs_q         <= '0;
      ends_q         <= '0;
      tmr_q          <= '0;
      flp_cnt_q      <= '0;
      chk_start_q    <= 1'b0;
      flp_start_q    <= 1'b0;
      accepted_q     <= 1'b0;
      rejected_q     <= 1'b0;
      black_cnt_q    <= 7'd2;
      white_cnt_q    <= 7'd2;
    end else begin
      state_q        <= state_d;
      board_q        <= board_d;
      player_black_q <= player_black_d;
      game_over_q    <= game_over_d;
      pass_cnt_q     <= pass_cnt_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dirs_q         <= dirs_d;
      ends_q         <= ends_d;
      tmr_q          <= tmr_d;
      flp_cnt_q      <= flp_cnt_d;
      chk_start_q    <= chk_start_d;
      flp_start_q    <= flp_start_d;
      accepted_q     <= accepted_d;
      rejected_q     <= rejected_d;
      black_cnt_q    <= black_cnt_d;
      white_cnt_q    <= white_cnt_d;
    end
  end

  assign chk_start     = chk_start_q;
  assign chk_x         = x_q;
  assign chk_y         = y_q;
  assign flp_start     = flp_start_q;
  assign flp_dirs      = dirs_q;
  assign flp_ends      = ends_q;
  assign board         = board_q;
  assign player_black  = player_black_q;
  assign move_accepted = accepted_q;
  assign move_rejected = rejected_q;
  assign black_cnt     = black_cnt_q;
  assign white_cnt     = white_cnt_q;
  assign game_over     = game_over_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: checker/flip BFMs plus a scoreboard of
// expected accept/reject outcomes with the board and turn they should leave.
module tb_move_sequencer;
  import reversi_pkg::*;

  localparam int unsigned FlipLat = 1;
  localparam int unsigned ChkTmo  = 255;

  logic         clk = 1'b0;
  logic         resetn, new_game, move_valid, pass_req, chk_done;
  logic [2:0]   move_x, move_y;
  logic [7:0]   chk_dirs;
  logic [47:0]  chk_ends;
  logic [127:0] flp_new_board;
  logic         move_ready, chk_start, flp_start, player_black;
  logic         move_accepted, move_rejected, game_over;
  logic [2:0]   chk_x, chk_y;
  logic [7:0]   flp_dirs;
  logic [47:0]  flp_ends;
  logic [127:0] board;
  logic [6:0]   black_cnt, white_cnt;

  move_sequencer #(
    .FLIP_LAT (FlipLat),
    .CHK_TMO  (ChkTmo)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .new_game      (new_game),
    .move_valid    (move_valid),
    .move_ready    (move_ready),
    .move_x        (move_x),
    .move_y        (move_y),
    .pass_req      (pass_req),
    .chk_start     (chk_start),
    .chk_x         (chk_x),
    .chk_y         (chk_y),
    .chk_done      (chk_done),
    .chk_dirs      (chk_dirs),
    .chk_ends      (chk_ends),
    .flp_start     (flp_start),
    .flp_dirs      (flp_dirs),
    .flp_ends      (flp_ends),
    .flp_new_board (flp_new_board),
    .board         (board),
    .player_black  (player_black),
    .move_accepted (move_accepted),
    .move_rejected (move_rejected),
    .black_cnt     (black_cnt),
    .white_cnt     (white_cnt),
    .game_over     (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           accepted;
    logic [127:0] board;
    bit           player_black;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         sb_e;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc = 0;
  int           t_chk = 0;
  int           t_rej = 0;
  int           n_chk_start = 0;
  int           chk_pend = 0;
  int           bfm_lat = 2;
  bit           bfm_silent = 1'b0;
  logic [7:0]   bfm_dirs = '0;
  logic [47:0]  bfm_ends = '0;
  logic [127:0] exp_b2;
  int           nchk0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] set_cell(input logic [127:0] b, input int idx,
                                            input logic [1:0] col);
    logic [127:0] r;
    r = b;
    r[2*idx +: 2] = col;
    return r;
  endfunction

  // Reference flip: walk each legal direction from the placed cell up to its end cell.
  function automatic logic [127:0] flip_model(input logic [127:0] b, input logic [2:0] x,
                                              input logic [2:0] y, input logic [7:0] dirs,
                                              input logic [47:0] ends, input bit blk);
    int dx[8] = '{1, 1, 0, -1, -1, -1, 0, 1};
    int dy[8] = '{0, -1, -1, -1, 0, 1, 1, 1};
    logic [127:0] r;
    logic [1:0]   col;
    int cx, cy;
    r   = b;
    col = blk ? CELL_BLACK : CELL_WHITE;
    for (int d = 0; d < 8; d++) begin
      if (dirs[d]) begin
        cx = int'(x) + dx[d];
        cy = int'(y) + dy[d];
        for (int s = 0; s < 7; s++) begin
          if (cx < 0 || cx > 7 || cy < 0 || cy > 7) break;
          if (cy * 8 + cx == int'(ends[6*d +: 6])) break;
          r[2*(cy*8+cx) +: 2] = col;
          cx += dx[d];
          cy += dy[d];
        end
      end
    end
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Checker and flip-datapath BFMs.
  always @(negedge clk) begin
    chk_done = 1'b0;
    if (chk_pend > 0) begin
      chk_pend--;
      if (chk_pend == 0) begin
        chk_done = 1'b1;
        chk_dirs = bfm_dirs;
        chk_ends = bfm_ends;
      end
    end
    if (chk_start && !bfm_silent) chk_pend = bfm_lat;
    if (flp_start) flp_new_board = flip_model(board, chk_x, chk_y, flp_dirs, flp_ends,
                                              player_black);
    if (!resetn) chk_pend = 0;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (chk_start) begin
      n_chk_start++;
      t_chk = cyc;
    end
    if (move_rejected) t_rej = cyc;
    if (flp_start) begin
      check("flp_dirs", flp_dirs, bfm_dirs);
      check("flp_ends", flp_ends, bfm_ends);
    end
    if (move_accepted || move_rejected) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {move_accepted, move_rejected}, 2'b00);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_kind", move_accepted, sb_e.accepted);
        check("sb_board", board, sb_e.board);
        check("sb_player", player_black, sb_e.player_black);
      end
    end
  end

  task automatic do_move(input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    move_x     = x;
    move_y     = y;
    move_valid = 1'b1;
    for (int i = 0; i < 50 && !move_ready; i++) @(negedge clk);
    check("move_ready", move_ready, 1'b1);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic wait_sb(input string tag);
    for (int i = 0; i < 400 && sb_q.size() != 0; i++) @(negedge clk);
    check({tag, "_outcome"}, sb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_pass();
    @(negedge clk);
    pass_req = 1'b1;
    @(negedge clk);
    pass_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    resetn     = 1'b0;
    new_game   = 1'b0;
    move_valid = 1'b0;
    pass_req   = 1'b0;
    move_x     = '0;
    move_y     = '0;
    chk_done   = 1'b0;
    chk_dirs   = '0;
    chk_ends   = '0;
    flp_new_board = '0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_board", board, START_BOARD);
    check("rst_black", black_cnt, 7'd2);
    check("rst_white", white_cnt, 7'd2);
    check("rst_player", player_black, 1'b1);
    check("rst_ready", move_ready, 1'b1);
    check("rst_over", game_over, 1'b0);

    // Legal black move at (2,3) flipping cell 27
    bfm_dirs = 8'h01;
    bfm_ends = 48'd28;
    exp_b2 = set_cell(set_cell(START_BOARD, 26, CELL_BLACK), 27, CELL_BLACK);
    sb_q.push_back('{1'b1, exp_b2, 1'b0});
    do_move(3'd2, 3'd3);
    wait_sb("legal");
    check("legal_black_cnt", black_cnt, 7'd4);
    check("legal_white_cnt", white_cnt, 7'd1);
    check("legal_over", game_over, 1'b0);

    // Occupied cell (3,3): rejected without consulting the checker
    nchk0 = n_chk_start;
    sb_q.push_back('{1'b0, exp_b2, 1'b0});
    do_move(3'd3, 3'd3);
    wait_sb("occupied");
    check("occupied_no_chk", n_chk_start, nchk0);

    // Checker reports no legal direction
    bfm_dirs = 8'h00;
    sb_q.push_back('{1'b0, exp_b2, 1'b0});
    do_move(3'd5, 3'd5);
    wait_sb("illegal");
    check("illegal_black_cnt", black_cnt, 7'd4);

    // Silent checker: reject exactly ChkTmo cycles after chk_start
    bfm_silent = 1'b1;
    sb_q.push_back('{1'b0, exp_b2, 1'b0});
    do_move(3'd4, 3'd2);
    wait_sb("timeout");
    check("timeout_latency", t_rej - t_chk, ChkTmo);
    bfm_silent = 1'b0;

    // Two consecutive passes end the game
    do_pass();
    check("pass1_player", player_black, 1'b1);
    check("pass1_over", game_over, 1'b0);
    do_pass();
    check("pass2_player", player_black, 1'b0);
    check("pass2_over", game_over, 1'b1);
    check("pass2_ready", move_ready, 1'b0);
    do_pass();
    check("pass3_ignored", player_black, 1'b0);

    // new_game restores the start position
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    check("ng_board", board, START_BOARD);
    check("ng_over", game_over, 1'b0);
    check("ng_player", player_black, 1'b1);

    // Reset in the middle of FLIP aborts the move
    bfm_dirs = 8'h01;
    bfm_ends = 48'd28;
    do_move(3'd2, 3'd3);
    for (int i = 0; i < 20 && !flp_start; i++) @(negedge clk);
    check("mid_flip_seen", flp_start, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("rflip_board", board, START_BOARD);
    check("rflip_over", game_over, 1'b0);
    check("rflip_player", player_black, 1'b1);
    check("rflip_ready", move_ready, 1'b1);
    check("rflip_black", black_cnt, 7'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
